scan_seg_display_n: RTL
=======================

SCAN_SEG_DISPLAY_N -- requirements
Module: scan_seg_display_n

Interface
REQ-001 Parameter DIGITS, default 6, number of multiplexed digits, legal range 1..8.
REQ-002 Parameter DIV, default 50000, clock cycles per digit slot, legal range 4..2^20.
REQ-003 Parameter DEAD, default 16, blanking cycles at the start of each slot (ghost suppression), legal range 0..DIV-2.
REQ-004 Parameter AN_ACT_LOW, default 1, 1 = digit selects active-low.
REQ-005 Parameter SEG_ACT_LOW, default 1, 1 = segments and dp active-low (common anode).
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst_n  in  1  reset, synchronous and active-high, despite the name.
REQ-008 load  in  1  single-cycle strobe that captures hex_in, dp_in and en_in into the pending registers.
REQ-009 hex_in  in  4*DIGITS  nibble k, bits [4k+3:4k], is the value for digit k.
REQ-010 dp_in  in  DIGITS  bit k = 1 lights the decimal point of digit k.
REQ-011 en_in  in  DIGITS  bit k = 0 blanks digit k for the whole of its slot.
REQ-012 bright  in  4  brightness; sampled every cycle, not latched by load.
REQ-013 an  out  DIGITS  registered digit selects; bit k drives digit k.
REQ-014 sseg  out  8  registered segments: [7]=dp, [6]=a, [5]=b, [4]=c, [3]=d, [2]=e, [1]=f, [0]=g.
REQ-015 frame_done  out  1  one-cycle pulse in the last cycle of slot DIGITS-1.

Function
REQ-016 Slot counter cnt SHALL count 0..DIV-1 and wrap; digit index idx SHALL advance when cnt wraps, going 0..DIGITS-1 then back to 0 (DIGITS=1: idx stays 0).
REQ-017 load SHALL write the pending registers; when load is high at the frame-end cycle (frame_done), the new values SHALL still be captured.
REQ-018 The active registers SHALL copy the pending registers on the cycle idx wraps to 0; no digit SHALL show a mixed old/new frame.
REQ-019 A 4-bit free-running counter pwm SHALL increment every cycle.
REQ-020 Digit idx is lit only when cnt >= DEAD, en bit idx = 1, and pwm <= bright; duty is (bright+1)/16, and bright=15 gives full on.
REQ-021 When lit: only an bit idx is active and sseg carries the decode of the active nibble plus the dp bit; when not lit: all an bits and all sseg bits are inactive.
REQ-022 Logical (active-high) decode g..a order as [6:0], a=bit6: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-023 Output polarity: a physical bit is the logical value inverted when the matching *_ACT_LOW parameter is 1.
REQ-024 an and sseg SHALL be registered: their value in cycle n+1 reflects cnt, idx, pwm and bright in cycle n (latency 1).
REQ-025 frame_done SHALL be registered with the same one-cycle alignment as an and sseg.
REQ-026 No cycle SHALL have more than one an bit active.

Reset
REQ-027 While rst_n=1 at a clock edge: cnt, idx and pwm = 0; pending and active registers = 0, with en = all 1s and dp = 0.
REQ-028 Outputs on the cycle after reset: an and sseg all inactive, frame_done = 0.
REQ-029 Reset asserted in mid-slot or mid-frame SHALL abort the frame; the next frame starts at idx 0 and cnt 0 on the first cycle after reset is released.

Verification
REQ-030 DIGITS=4, DIV=8, DEAD=2, bright=15; load hex_in=16'h3210, en=4'hF, dp=0 -> per slot: 2 cycles dark, then 6 cycles with an one-hot; digit 0 shows physical sseg 8'b1000_0001; frame_done pulses every 32 cycles.
REQ-031 Same setup; load new values in the middle of slot 2 -> slots 2 and 3 keep the old values, and the new values appear from slot 0 of the next frame.
REQ-032 bright=3 -> digit lit in exactly 4 of every 16 cycles outside the dead window; bright=15 -> lit in every cycle outside the dead window.
REQ-033 en_in=4'b1011, dp_in=4'b0001 -> digit 2 dark for its whole slot; digit 0 shows sseg[7] active.
REQ-034 DIGITS=1, DIV=4, DEAD=0 -> an[0] stays active and frame_done pulses every 4 cycles.
REQ-035 rst_n pulsed for one cycle during slot 1 -> outputs inactive on the next cycle, and the following frame restarts at idx 0 with cnt 0.

Source files
------------

// File: rtl/scan_seg_display_n.sv
// Time-multiplexed 7-segment driver: one digit per DIV-cycle slot, dead-time blanking, PWM brightness.
// an/sseg/frame_done are registered (1-cycle latency); load is always accepted, and frames swap in at frame end.
module scan_seg_display_n #(
   parameter int DIGITS      = 6,
   parameter int DIV         = 50000,
   parameter int DEAD        = 16,
   parameter int AN_ACT_LOW  = 1,
   parameter int SEG_ACT_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   hex_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     en_in,
   input  logic [3:0]            bright,
   output logic [DIGITS-1:0]     an,
   output logic [7:0]            sseg,
   output logic                  frame_done
);

   localparam int CW = $clog2(DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
   localparam logic [DIGITS-1:0] AN_OFF = (AN_ACT_LOW != 0) ? '1 : '0;
   localparam logic [7:0] SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [3:0]            pwm_q, pwm_d;
   logic [4*DIGITS-1:0]   hex_p_q, hex_p_d, hex_a_q, hex_a_d;
   logic [DIGITS-1:0]     dp_p_q, dp_p_d, dp_a_q, dp_a_d;
   logic [DIGITS-1:0]     en_p_q, en_p_d, en_a_q, en_a_d;
   logic [DIGITS-1:0]     an_q, an_d;
   logic [7:0]            sseg_q, sseg_d;
   logic                  frame_done_q, frame_done_d;

   logic                  cnt_wrap;
   logic                  frame_end;
   logic                  dead_ok;
   logic                  lit;
   logic [3:0]            nib;
   logic [DIGITS-1:0]     an_log;
   logic [7:0]            seg_log;

   function automatic logic [6:0] dec7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'b1111110;
         4'h1:    s = 7'b0110000;
         4'h2:    s = 7'b1101101;
         4'h3:    s = 7'b1111001;
         4'h4:    s = 7'b0110011;
         4'h5:    s = 7'b1011011;
         4'h6:    s = 7'b1011111;
         4'h7:    s = 7'b1110000;
         4'h8:    s = 7'b1111111;
         4'h9:    s = 7'b1111011;
         4'hA:    s = 7'b1110111;
         4'hB:    s = 7'b0011111;
         4'hC:    s = 7'b1001110;
         4'hD:    s = 7'b0111101;
         4'hE:    s = 7'b1001111;
         default: s = 7'b1000111;
      endcase
      return s;
   endfunction

   // With no dead window the comparison would be trivially true.
   generate
      if (DEAD == 0) begin : g_no_dead
         assign dead_ok = 1'b1;
      end else begin : g_dead
         assign dead_ok = (cnt_q >= CW'(DEAD));
      end
   endgenerate

   always_comb begin
      cnt_wrap  = (cnt_q == CNT_MAX);
      frame_end = cnt_wrap && (idx_q == IDX_MAX);

      cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      if (cnt_wrap) begin
         idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      end
      pwm_d = pwm_q + 4'd1;

      hex_p_d = hex_p_q;
      dp_p_d  = dp_p_q;
      en_p_d  = en_p_q;
      if (load) begin
         hex_p_d = hex_in;
         dp_p_d  = dp_in;
         en_p_d  = en_in;
      end

      // Active copy takes the pending value held before this edge, so a
      // load coinciding with frame end lands in the following frame.
      hex_a_d = hex_a_q;
      dp_a_d  = dp_a_q;
      en_a_d  = en_a_q;
      if (frame_end) begin
         hex_a_d = hex_p_q;
         dp_a_d  = dp_p_q;
         en_a_d  = en_p_q;
      end

      nib     = hex_a_q[{idx_q, 2'b00} +: 4];
      lit     = dead_ok && en_a_q[idx_q] && (pwm_q <= bright);
      an_log  = lit ? (DIGITS'(1) << idx_q) : '0;
      seg_log = lit ? {dp_a_q[idx_q], dec7(nib)} : 8'h00;

      an_d         = (AN_ACT_LOW != 0) ? ~an_log : an_log;
      sseg_d       = (SEG_ACT_LOW != 0) ? ~seg_log : seg_log;
      frame_done_d = frame_end;
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         pwm_q        <= '0;
         hex_p_q      <= '0;
         dp_p_q       <= '0;
         en_p_q       <= '1;
         hex_a_q      <= '0;
         dp_a_q       <= '0;
         en_a_q       <= '1;
         an_q         <= AN_OFF;
         sseg_q       <= SEG_OFF;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         pwm_q        <= pwm_d;
         hex_p_q      <= hex_p_d;
         dp_p_q       <= dp_p_d;
         en_p_q       <= en_p_d;
         hex_a_q      <= hex_a_d;
         dp_a_q       <= dp_a_d;
         en_a_q       <= en_a_d;
         an_q         <= an_d;
         sseg_q       <= sseg_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign an         = an_q;
   assign sseg       = sseg_q;
   assign frame_done = frame_done_q;

endmodule
